// File: rtl/dii_packet_buffer.sv
// dii_packet_buffer: circular-buffer FIFO for DII flits.
//
// The dii_flit type (valid, last, data) is defined in dii_package below. Its
// data field is 16 bits wide, so WIDTH must stay at 16.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   flit_in         write-side flit (valid, last, data)
//   flit_in_ready   write-side ready; depends only on buffer state
//   flit_out        read-side flit; data/last read combinationally at rd_ptr
//   flit_out_ready  read-side ready
//   fill_level      flits stored, 0..DEPTH
//   packet_count    stored flits with last=1 (complete packets)
//   packet_size     flits in the head packet (count when no last is stored)
//   fill_max        high-water mark of fill_level, sticky until reset
//                   (present only when DII_PACKET_BUFFER_HWM_EN is defined)
//
// Parameters: WIDTH (16), DEPTH (power of two, >= 2), and FULLPACKET
// (1 = store-and-forward, 0 = cut-through). With FULLPACKET=1 a full buffer
// also presents valid, so a packet longer than DEPTH drains instead of
// deadlocking.

package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module dii_packet_buffer
  import dii_package::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int FULLPACKET = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  dii_flit                flit_in,
  output logic                   flit_in_ready,
  output dii_flit                flit_out,
  input  logic                   flit_out_ready,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [$clog2(DEPTH):0] packet_count,
  output logic [$clog2(DEPTH):0] packet_size
`ifdef DII_PACKET_BUFFER_HWM_EN
  ,
  output logic [$clog2(DEPTH):0] fill_max
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_last [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_next;
  logic [AW:0]   pkt_cnt, pkt_cnt_next;
  logic          push, pop, out_valid;
  logic          push_last, pop_last;

  assign flit_in_ready = rst_n & (count != FULL);
  assign push          = flit_in.valid & flit_in_ready;
  assign pop           = out_valid & flit_out_ready;
  assign push_last     = push & flit_in.last;
  assign pop_last      = pop & mem_last[rd_ptr];

  always_comb begin
    if (FULLPACKET != 0) out_valid = (pkt_cnt != '0) | (count == FULL);
    else                 out_valid = (count != '0);
  end

  always_comb begin
    flit_out       = '0;
    flit_out.valid = out_valid;
    flit_out.last  = mem_last[rd_ptr];
    flit_out.data  = mem_data[rd_ptr];
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
    pkt_cnt_next = pkt_cnt;
    case ({push_last, pop_last})
      2'b10:   pkt_cnt_next = pkt_cnt + (AW+1)'(1);
      2'b01:   pkt_cnt_next = pkt_cnt - (AW+1)'(1);
      default: pkt_cnt_next = pkt_cnt;
    endcase
  end

  // Storage is deliberately not reset; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= flit_in.data;
      mem_last[wr_ptr] <= flit_in.last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      pkt_cnt <= pkt_cnt_next;
    end
  end

  // Head-packet size: distance from rd_ptr to the first stored last flit,
  // scanning only occupied entries; falls back to count when none is stored.
  always_comb begin
    logic          found;
    logic [AW-1:0] idx;
    found       = 1'b0;
    idx         = rd_ptr;
    packet_size = count;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (!found && ((AW+1)'(i) < count) && mem_last[idx]) begin
        packet_size = (AW+1)'(i + 1);
        found       = 1'b1;
      end
    end
  end

  assign fill_level   = count;
  assign packet_count = pkt_cnt;

`ifdef DII_PACKET_BUFFER_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     fill_max <= '0;
    else if (count_next > fill_max) fill_max <= count_next;
  end
`endif

endmodule

// File: tb/tb_dii_packet_buffer.sv
// Directed bench for dii_packet_buffer: three instances cover cut-through
// (DEPTH=4), store-and-forward (DEPTH=8) and the oversized-packet escape
// (DEPTH=4, FULLPACKET=1).

module tb_dii_packet_buffer;
  import dii_package::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dii_flit a_in, a_out, b_in, b_out, c_in, c_out;
  logic a_in_ready, a_out_ready, b_in_ready, b_out_ready, c_in_ready, c_out_ready;
  logic [2:0] a_fill, a_pc, a_ps, c_fill, c_pc, c_ps;
  logic [3:0] b_fill, b_pc, b_ps;
`ifdef DII_PACKET_BUFFER_HWM_EN
  logic [2:0] a_max, c_max;
  logic [3:0] b_max;
`endif

  int total = 0;
  int bad   = 0;

  dii_packet_buffer #(.WIDTH(16), .DEPTH(4), .FULLPACKET(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flit_in(a_in), .flit_in_ready(a_in_ready),
    .flit_out(a_out), .flit_out_ready(a_out_ready), .fill_level(a_fill),
    .packet_count(a_pc), .packet_size(a_ps)
`ifdef DII_PACKET_BUFFER_HWM_EN
    , .fill_max(a_max)
`endif
  );

  dii_packet_buffer #(.WIDTH(16), .DEPTH(8), .FULLPACKET(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flit_in(b_in), .flit_in_ready(b_in_ready),
    .flit_out(b_out), .flit_out_ready(b_out_ready), .fill_level(b_fill),
    .packet_count(b_pc), .packet_size(b_ps)
`ifdef DII_PACKET_BUFFER_HWM_EN
    , .fill_max(b_max)
`endif
  );

  dii_packet_buffer #(.WIDTH(16), .DEPTH(4), .FULLPACKET(1)) u_c (
    .clk(clk), .rst_n(rst_n), .flit_in(c_in), .flit_in_ready(c_in_ready),
    .flit_out(c_out), .flit_out_ready(c_out_ready), .fill_level(c_fill),
    .packet_count(c_pc), .packet_size(c_ps)
`ifdef DII_PACKET_BUFFER_HWM_EN
    , .fill_max(c_max)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_in = '0; b_in = '0; c_in = '0;
    a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", a_in_ready); end
    total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", a_out.valid); end
    total++; if (a_fill !== 3'd0) begin bad++; $display("FAIL rst_fill got=%0d exp=0", a_fill); end
    #11;
    rst_n = 1'b1;
    tick();
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", a_in_ready); end
    total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", a_out.valid); end
    total++; if ({a_fill, a_pc, a_ps} !== 9'd0) begin bad++; $display("FAIL idle_counts got=%0d/%0d/%0d exp=0/0/0", a_fill, a_pc, a_ps); end
    total++; if (c_in_ready !== 1'b1 || c_out.valid !== 1'b0) begin bad++; $display("FAIL idle_c got=%b%b exp=10", c_in_ready, c_out.valid); end
  endtask

  task automatic test_cut_through;
    a_out_ready = 1'b0;
    a_in.valid = 1'b1; a_in.last = 1'b0; a_in.data = 16'h00A1;
    #1;
    total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL no_fallthrough got=%b exp=0", a_out.valid); end
    tick();
    total++; if (a_out.valid !== 1'b1 || a_out.data !== 16'h00A1) begin bad++; $display("FAIL ct_first got=%b/%h exp=1/00a1", a_out.valid, a_out.data); end
    total++; if (a_fill !== 3'd1 || a_ps !== 3'd1) begin bad++; $display("FAIL ct_fill1 got=%0d/%0d exp=1/1", a_fill, a_ps); end
    a_in.data = 16'h00A2; a_in.last = 1'b1;
    tick();
    a_in.valid = 1'b0;
    total++; if (a_fill !== 3'd2 || a_pc !== 3'd1 || a_ps !== 3'd2) begin bad++; $display("FAIL ct_counts got=%0d/%0d/%0d exp=2/1/2", a_fill, a_pc, a_ps); end
    total++; if (a_out.data !== 16'h00A1 || a_out.last !== 1'b0) begin bad++; $display("FAIL ct_head got=%h/%b exp=00a1/0", a_out.data, a_out.last); end
    a_out_ready = 1'b1;
    tick();
    total++; if (a_out.data !== 16'h00A2 || a_out.last !== 1'b1 || a_fill !== 3'd1 || a_ps !== 3'd1) begin bad++; $display("FAIL ct_pop1 got=%h/%b/%0d/%0d exp=00a2/1/1/1", a_out.data, a_out.last, a_fill, a_ps); end
    tick();
    total++; if (a_out.valid !== 1'b0 || a_fill !== 3'd0 || a_pc !== 3'd0 || a_ps !== 3'd0) begin bad++; $display("FAIL ct_empty got=%b/%0d/%0d/%0d exp=0/0/0/0", a_out.valid, a_fill, a_pc, a_ps); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_full_wrap;
    logic [15:0] exp_out, nxt_in;
    logic p;
    a_out_ready = 1'b0;
    a_in.last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in.valid = 1'b1; a_in.data = 16'(16'h0010 + i);
      tick();
    end
    a_in.valid = 1'b0;
    total++; if (a_in_ready !== 1'b0 || a_fill !== 3'd4) begin bad++; $display("FAIL full got=%b/%0d exp=0/4", a_in_ready, a_fill); end
    total++; if (a_ps !== 3'd4 || a_pc !== 3'd0) begin bad++; $display("FAIL full_nolast got=%0d/%0d exp=4/0", a_ps, a_pc); end
    exp_out = 16'h0010; nxt_in = 16'h0014;
    a_out_ready = 1'b1; a_in.valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      a_in.data = nxt_in;
      total++; if (a_out.valid !== 1'b1 || a_out.data !== exp_out) begin bad++; $display("FAIL wrap_order got=%b/%h exp=1/%h", a_out.valid, a_out.data, exp_out); end
      p = a_in_ready;
      tick();
      exp_out++;
      if (p) nxt_in++;
      if (cyc == 0) begin
        total++; if (a_fill !== 3'd3 || a_in_ready !== 1'b1) begin bad++; $display("FAIL full_pop got=%0d/%b exp=3/1", a_fill, a_in_ready); end
      end
    end
    a_in.valid = 1'b0;
    total++; if (a_fill !== 3'd3 || a_ps !== 3'd3) begin bad++; $display("FAIL wrap_fill got=%0d/%0d exp=3/3", a_fill, a_ps); end
    for (int k = 0; k < 3; k++) begin
      total++; if (a_out.data !== exp_out) begin bad++; $display("FAIL wrap_drain got=%h exp=%h", a_out.data, exp_out); end
      tick();
      exp_out++;
    end
    total++; if (a_fill !== 3'd0 || a_out.valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%0d/%b exp=0/0", a_fill, a_out.valid); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_pc_both;
    a_out_ready = 1'b0;
    a_in.valid = 1'b1; a_in.last = 1'b1; a_in.data = 16'h00B1;
    tick();
    total++; if (a_pc !== 3'd1) begin bad++; $display("FAIL pc_push got=%0d exp=1", a_pc); end
    a_in.data = 16'h00B2; a_out_ready = 1'b1;
    tick();
    a_in.valid = 1'b0;
    total++; if (a_pc !== 3'd1 || a_fill !== 3'd1 || a_out.data !== 16'h00B2 || a_ps !== 3'd1) begin bad++; $display("FAIL pc_both got=%0d/%0d/%h/%0d exp=1/1/00b2/1", a_pc, a_fill, a_out.data, a_ps); end
    tick();
    total++; if (a_pc !== 3'd0 || a_fill !== 3'd0) begin bad++; $display("FAIL pc_pop got=%0d/%0d exp=0/0", a_pc, a_fill); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_store_forward;
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in.valid = 1'b1; b_in.data = 16'(16'h0031 + i); b_in.last = (i == 2);
      #1;
      total++; if (b_out.valid !== 1'b0) begin bad++; $display("FAIL sf_hold%0d got=%b exp=0", i, b_out.valid); end
      tick();
    end
    b_in.valid = 1'b0;
    total++; if (b_out.valid !== 1'b1 || b_out.data !== 16'h0031) begin bad++; $display("FAIL sf_valid got=%b/%h exp=1/0031", b_out.valid, b_out.data); end
    total++; if (b_pc !== 4'd1 || b_ps !== 4'd3 || b_fill !== 4'd3) begin bad++; $display("FAIL sf_counts got=%0d/%0d/%0d exp=1/3/3", b_pc, b_ps, b_fill); end
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (b_out.valid !== 1'b1 || b_out.data !== 16'(16'h0031 + i) || b_out.last !== (i == 2)) begin bad++; $display("FAIL sf_pop%0d got=%b/%h/%b exp=1/%h/%b", i, b_out.valid, b_out.data, b_out.last, 16'(16'h0031 + i), (i == 2)); end
      tick();
    end
    total++; if (b_pc !== 4'd0 || b_out.valid !== 1'b0 || b_fill !== 4'd0) begin bad++; $display("FAIL sf_empty got=%0d/%b/%0d exp=0/0/0", b_pc, b_out.valid, b_fill); end
    b_out_ready = 1'b0;
  endtask

  task automatic test_escape;
    int sent, got;
    logic pu, po;
    c_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_in.valid = 1'b1; c_in.data = 16'(16'h0061 + i); c_in.last = 1'b0;
      tick();
      total++; if (c_out.valid !== (i == 3)) begin bad++; $display("FAIL esc_valid%0d got=%b exp=%b", i, c_out.valid, (i == 3)); end
    end
    total++; if (c_fill !== 3'd4 || c_pc !== 3'd0 || c_in_ready !== 1'b0) begin bad++; $display("FAIL esc_full got=%0d/%0d/%b exp=4/0/0", c_fill, c_pc, c_in_ready); end
    sent = 4; got = 0;
    c_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      c_in.valid = (sent < 6); c_in.data = 16'(16'h0061 + sent); c_in.last = (sent == 5);
      pu = c_in.valid & c_in_ready;
      po = c_out.valid;
      if (po) begin
        total++; if (c_out.data !== 16'(16'h0061 + got) || c_out.last !== (got == 5)) begin bad++; $display("FAIL esc_flit%0d got=%h/%b exp=%h/%b", got, c_out.data, c_out.last, 16'(16'h0061 + got), (got == 5)); end
        got++;
      end
      tick();
      if (pu) sent++;
    end
    c_in.valid = 1'b0; c_out_ready = 1'b0;
    total++; if (got != 6) begin bad++; $display("FAIL esc_delivered got=%0d exp=6", got); end
    total++; if (c_fill !== 3'd0 || c_pc !== 3'd0) begin bad++; $display("FAIL esc_empty got=%0d/%0d exp=0/0", c_fill, c_pc); end
  endtask

`ifdef DII_PACKET_BUFFER_HWM_EN
  task automatic test_hwm;
    total++; if (b_max !== 4'd3) begin bad++; $display("FAIL hwm_prev got=%0d exp=3", b_max); end
    b_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_in.valid = 1'b1; b_in.data = 16'(16'h0050 + i); b_in.last = (i == 4);
      tick();
    end
    b_in.valid = 1'b0;
    total++; if (b_fill !== 4'd5 || b_max !== 4'd5) begin bad++; $display("FAIL hwm_fill got=%0d/%0d exp=5/5", b_fill, b_max); end
    b_out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && b_fill != 4'd0; cyc++) tick();
    b_out_ready = 1'b0;
    total++; if (b_fill !== 4'd0 || b_max !== 4'd5) begin bad++; $display("FAIL hwm_hold got=%0d/%0d exp=0/5", b_fill, b_max); end
  endtask
`endif

  task automatic test_reset_mid;
    a_out_ready = 1'b0;
    a_in.valid = 1'b1; a_in.last = 1'b1; a_in.data = 16'h00C1;
    tick();
    a_in.last = 1'b0; a_in.data = 16'h00C2;
    tick();
    a_in.valid = 1'b0;
    total++; if (a_fill !== 3'd2) begin bad++; $display("FAIL mid_pre got=%0d exp=2", a_fill); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (a_fill !== 3'd0 || a_pc !== 3'd0 || a_ps !== 3'd0) begin bad++; $display("FAIL mid_counts got=%0d/%0d/%0d exp=0/0/0", a_fill, a_pc, a_ps); end
    total++; if (a_out.valid !== 1'b0 || a_in_ready !== 1'b0) begin bad++; $display("FAIL mid_hs got=%b/%b exp=0/0", a_out.valid, a_in_ready); end
`ifdef DII_PACKET_BUFFER_HWM_EN
    total++; if (b_max !== 4'd0) begin bad++; $display("FAIL hwm_reset got=%0d exp=0", b_max); end
`endif
    #2;
    rst_n = 1'b1;
    tick();
    total++; if (a_in_ready !== 1'b1 || a_out.valid !== 1'b0 || a_fill !== 3'd0) begin bad++; $display("FAIL mid_after got=%b/%b/%0d exp=1/0/0", a_in_ready, a_out.valid, a_fill); end
  endtask

  initial begin
    test_reset();
    test_cut_through();
    test_full_wrap();
    test_pc_both();
    test_store_forward();
    test_escape();
`ifdef DII_PACKET_BUFFER_HWM_EN
    test_hwm();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
